vga_timing_gen: RTL and testbench

Parametrised video timing generator: derives a pixel-rate enable from the system clock, runs horizontal and vertical position counters over a full frame including blanking, and produces sync, active-video and frame-buffer address outputs. It feeds the display output stage and the frame-buffer read port. Every timing constant is a parameter, so any standard mode or a small test mode can be built from the same block.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Video timing generator: pixel-rate divider, column/row counters over the full
// frame including blanking, sync/active decodes and frame-buffer address.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  output logic              pixel_ce,
  output logic [CNT_W-1:0]  col,
  output logic [CNT_W-1:0]  row,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic              line_start,
  output logic              frame_start,
  output logic              frame_done
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DEPTH     = H_ACTIVE * V_ACTIVE;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [31:0] col_w;
  logic [31:0] row_w;
  logic        col_wrap;
  logic        row_wrap;
  logic        addr_wrap;

  // State registers; reset wins over enable
  always_ff @(posedge clk) begin
    if (n_rst) begin
      div_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
    end
  end

  // Decodes and next-state; counter wraps all resolve in the same cycle
  always_comb begin
    div_cnt_d   = div_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    col_w       = 32'(col_q);
    row_w       = 32'(row_q);

    pixel_ce    = enable && !n_rst && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    active      = (col_w < H_ACTIVE) && (row_w < V_ACTIVE);
    hsync       = ((col_w >= HS_START) && (col_w < HS_END)) ? HS_POL : ~HS_POL;
    vsync       = ((row_w >= VS_START) && (row_w < VS_END)) ? VS_POL : ~VS_POL;
    col_wrap    = (col_w == H_TOTAL - 1);
    row_wrap    = (row_w == V_TOTAL - 1);
    addr_wrap   = (32'(addr_q) == DEPTH - 1);

    line_start  = pixel_ce && (col_q == '0);
    frame_start = pixel_ce && (col_q == '0) && (row_q == '0);
    frame_done  = pixel_ce && active && addr_wrap;

    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
    end

    if (pixel_ce) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      if (active) begin
        addr_d = addr_wrap ? '0 : addr_q + ADDR_W'(1);
      end
      // Frame wrap re-aligns addr even if it has drifted
      if (col_wrap && row_wrap) begin
        addr_d = '0;
      end
    end

    col  = col_q;
    row  = row_q;
    addr = addr_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode, a mid-size mode and the
// small test mode, each on its own instance.
module tb_vga_timing_gen;

  logic clk;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default 640x480 mode
  logic d_rst, d_en, d_ce, d_hs, d_vs, d_act, d_ls, d_fs, d_fd;
  logic [9:0]  d_col, d_row;
  logic [18:0] d_addr;
  vga_timing_gen u_def (
    .clk(clk), .n_rst(d_rst), .enable(d_en), .pixel_ce(d_ce), .col(d_col), .row(d_row),
    .hsync(d_hs), .vsync(d_vs), .active(d_act), .addr(d_addr), .line_start(d_ls),
    .frame_start(d_fs), .frame_done(d_fd));

  // Mid mode: H 16/2/4/2 (24), V 12/2/2/2 (18), CLK_DIV 3, positive vsync
  logic m_rst, m_en, m_ce, m_hs, m_vs, m_act, m_ls, m_fs, m_fd;
  logic [4:0] m_col, m_row;
  logic [7:0] m_addr;
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2),
    .V_BP(2), .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(5), .ADDR_W(8)
  ) u_mid (
    .clk(clk), .n_rst(m_rst), .enable(m_en), .pixel_ce(m_ce), .col(m_col), .row(m_row),
    .hsync(m_hs), .vsync(m_vs), .active(m_act), .addr(m_addr), .line_start(m_ls),
    .frame_start(m_fs), .frame_done(m_fd));

  // Small mode: H 4/1/2/1 (8), V 3/1/1/1 (6), CLK_DIV 1, positive hsync
  logic s_rst, s_en, s_ce, s_hs, s_vs, s_act, s_ls, s_fs, s_fd;
  logic [2:0] s_col, s_row;
  logic [3:0] s_addr;
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(3), .ADDR_W(4)
  ) u_sm (
    .clk(clk), .n_rst(s_rst), .enable(s_en), .pixel_ce(s_ce), .col(s_col), .row(s_row),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .addr(s_addr), .line_start(s_ls),
    .frame_start(s_fs), .frame_done(s_fd));

  typedef struct {
    int k;      // clk edges since reset release
    int col;
    int row;
    int addr;
    bit hs;
    bit vs;
    bit act;
    bit ce;
    bit ls;
    bit fs;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int k;
    int n;
    int errs;
    int cnt;
    int fd_cnt;
    int max_addr;
    bit prev_fd;
    bit found;
    int h_col, h_row, h_addr;

    clk = 1'b0;
    d_rst = 1'b1; d_en = 1'b1;
    m_rst = 1'b1; m_en = 1'b1;
    s_rst = 1'b1; s_en = 1'b1;

    vecs[0]  = '{0,    0,   0, 0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,    0,   0, 0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{2,    1,   0, 1,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1279, 639, 0, 639,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1280, 640, 0, 640,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1312, 656, 0, 640,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1503, 751, 0, 640,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1504, 752, 0, 640,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1599, 799, 0, 640,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1600, 0,   1, 640,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1601, 0,   1, 640,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3205, 2,   2, 1282, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // ---- default mode: reset state
    tick(); tick();
    check("def_rst_col", d_col, 0);
    check("def_rst_row", d_row, 0);
    check("def_rst_addr", d_addr, 0);
    check("def_rst_active", d_act, 1);
    check("def_rst_hsync", d_hs, 1);
    check("def_rst_vsync", d_vs, 1);
    check("def_rst_pulses", {d_ce, d_ls, d_fs, d_fd}, 0);
    d_rst = 1'b0;

    // ---- default mode: table of positions along the first lines
    k = 0;
    for (int i = 0; i < 12; i++) begin
      while (k < vecs[i].k) begin
        tick();
        k++;
      end
      check($sformatf("vec%0d_col", i), d_col, vecs[i].col);
      check($sformatf("vec%0d_row", i), d_row, vecs[i].row);
      check($sformatf("vec%0d_addr", i), d_addr, vecs[i].addr);
      check($sformatf("vec%0d_hsync", i), d_hs, vecs[i].hs);
      check($sformatf("vec%0d_vsync", i), d_vs, vecs[i].vs);
      check($sformatf("vec%0d_active", i), d_act, vecs[i].act);
      check($sformatf("vec%0d_pixel_ce", i), d_ce, vecs[i].ce);
      check($sformatf("vec%0d_line_start", i), d_ls, vecs[i].ls);
      check($sformatf("vec%0d_frame_start", i), d_fs, vecs[i].fs);
    end

    // ---- enable drop at col 300 on the second divider phase
    while (k < 3801) begin
      tick();
      k++;
    end
    check("hold_pre_col", d_col, 300);
    check("hold_pre_ce", d_ce, 1);
    h_col = 300; h_row = 2; h_addr = 2 * 640 + 300;
    d_en = 1'b0;
    #1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (d_ce || d_ls || d_fs || d_fd) errs++;
      if (d_col != 10'(h_col) || d_row != 10'(h_row) || d_addr != 19'(h_addr)) errs++;
      if (d_act != 1'b1 || d_hs != 1'b1) errs++;
      tick();
    end
    check("hold_errs", errs, 0);
    check("hold_post_col", d_col, h_col);
    check("hold_post_addr", d_addr, h_addr);
    d_en = 1'b1;
    #1;
    check("resume_ce_same_phase", d_ce, 1);
    tick();
    check("resume_col", d_col, 301);
    check("resume_addr", d_addr, h_addr + 1);
    check("resume_ce", d_ce, 0);

    // ---- one full line: line_start period, hsync and active windows
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = d_ls;
    end
    check("line_start_found", found, 1);
    n = 0; errs = 0; cnt = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      tick();
      n++;
      if (d_hs == 1'b0) cnt++;
      if (d_hs != !((d_col >= 656) && (d_col <= 751))) errs++;
      if (d_act != (d_col < 640)) errs++;
      found = d_ls;
    end
    check("line_period_clk", n, 1600);
    check("line_hsync_low_clk", cnt, 96 * 2);
    check("line_window_errs", errs, 0);

    // ---- mid mode: full frame
    tick();
    m_rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = m_fs;
    end
    check("mid_frame_start_found", found, 1);
    n = 0; errs = 0; cnt = 0; fd_cnt = 0; max_addr = 0; prev_fd = 1'b0;
    found = 1'b0;
    while (!found && n < 3000) begin
      tick();
      n++;
      if (prev_fd && m_addr != 0) errs++;
      if (m_fd) begin
        fd_cnt++;
        check("mid_addr_at_done", m_addr, 191);
      end
      if (32'(m_addr) > max_addr) max_addr = 32'(m_addr);
      if (m_vs != ((m_row >= 14) && (m_row <= 15))) errs++;
      if (m_hs == 1'b0) cnt++;
      prev_fd = m_fd;
      found = m_fs;
    end
    check("mid_frame_period_clk", n, 24 * 18 * 3);
    check("mid_frame_done_count", fd_cnt, 1);
    check("mid_max_addr", max_addr, 191);
    check("mid_hsync_low_clk", cnt, 18 * 4 * 3);
    check("mid_frame_errs", errs, 0);

    // ---- mid mode: reset mid-frame at row 10, col 12
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      found = (m_row == 10) && (m_col == 12);
    end
    check("mid_reach_r10_c12", found, 1);
    m_rst = 1'b1;
    tick();
    check("mid_rst_col", m_col, 0);
    check("mid_rst_row", m_row, 0);
    check("mid_rst_addr", m_addr, 0);
    check("mid_rst_sync", {m_hs, m_vs, m_act}, 3'b101);
    check("mid_rst_pulses", {m_ce, m_ls, m_fs, m_fd}, 0);
    m_rst = 1'b0;
    #1;
    check("mid_restart_ce0", m_ce, 0);
    tick();
    check("mid_restart_ce1", m_ce, 0);
    tick();
    check("mid_restart_frame_start", {m_ce, m_fs, m_ls}, 3'b111);
    tick();
    check("mid_restart_col", m_col, 1);
    check("mid_restart_addr", m_addr, 1);

    // ---- small mode: three frames, one pixel per clk
    tick();
    check("sm_rst_sync", {s_hs, s_vs, s_act, s_ce}, 4'b0110);
    s_rst = 1'b0;
    #1;
    errs = 0; fd_cnt = 0;
    for (int kk = 0; kk < 3 * 48; kk++) begin
      int c, r, ea;
      c = kk % 8;
      r = (kk / 8) % 6;
      if (r < 3) ea = (c < 4) ? r * 4 + c : ((r + 1) * 4) % 12;
      else       ea = 0;
      if (s_col != 3'(c) || s_row != 3'(r)) errs++;
      if (s_hs != ((c >= 5) && (c <= 6))) errs++;
      if (s_vs != (r != 4)) errs++;
      if (s_act != ((c < 4) && (r < 3))) errs++;
      if (s_addr != 4'(ea)) errs++;
      if (s_fd != ((r == 2) && (c == 3))) errs++;
      if (s_ls != (c == 0) || s_fs != ((c == 0) && (r == 0)) || s_ce != 1'b1) errs++;
      if (s_fd) fd_cnt++;
      tick();
    end
    check("sm_frame_errs", errs, 0);
    check("sm_frame_done_count", fd_cnt, 3);
    check("sm_wrap_col", s_col, 0);
    check("sm_wrap_addr", s_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
